mem_req_queue: RTL and testbench
================================

# mem_req_queue

Request queue and sequencer that sits directly upstream of the memory, between the testbench-side requester and the memory port of the bus interface. It accepts read/write commands over a valid/ready handshake and buffers them in a small in-order FIFO. It issues one command per cycle as single-cycle memory read/write strobes, and returns each read's data with a one-cycle response strobe.

## Interface
- ADDR_W, 5, address width (32-word memory)
- DATA_W, 8, data width
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  requester presents a command
- req_ready  out  1  queue can accept a command this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  command address
- req_data  in  DATA_W  write data (ignored for reads)
- mem_read  out  1  read strobe to memory
- mem_write  out  1  write strobe to memory
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  read data from memory, valid the cycle after the read strobe's sampling edge
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_addr hold a read result
- rsp_addr  out  ADDR_W  address of the returned read
- rsp_data  out  DATA_W  returned read data
- busy  out  1  FIFO non-empty, or a command or read is in flight

## Operation
- Push: the command is accepted on any rising edge with req_valid && req_ready and written at the FIFO tail.
- req_ready = (count != DEPTH). It is combinational from the registered count, so a full queue does not accept a command even if it pops in the same cycle.
- Pop/issue: on each edge with count != 0, the head entry is loaded into the issue registers. mem_write or mem_read is then high for exactly one cycle, with mem_addr and mem_data_in driven.
- With count == 0 at an edge, both strobes go low. mem_addr and mem_data_in hold their last values.
- mem_read and mem_write are never high together.
- Simultaneous push and pop leaves count unchanged. Pointers are ADDR-independent and log2(DEPTH) bits wide, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- Read return pipeline:
  - Stage A: a registered flag and address track the read strobe one cycle later.
  - In the stage-A cycle, mem_data_out is captured into rsp_data and the address into rsp_addr, and rsp_valid pulses in the following cycle.
- No response backpressure. Responses return in issue order, one per cycle maximum.
- Writes produce no response.
- busy = (count != 0) || mem_read || mem_write || stage-A flag || rsp_valid.

## Timing
- Reset values: req_ready 1; mem_read, mem_write, rsp_valid, busy 0; mem_addr, mem_data_in, rsp_addr, rsp_data all 0. FIFO empty, pointers 0.
- Pushes presented while rst is high are ignored.
- Reset mid-operation: queued commands, the issued strobe and any in-flight read are discarded. No rsp_valid is produced for them.
- Timeline for an accept at edge E0 into an empty, idle queue:
  - Strobe high E1–E2; memory samples at E2.
  - Data captured at E3; rsp_valid high E3–E4.
  - Read latency is 3 edges from accept to rsp_valid.
  - A write reaches memory at E2.
- Throughput: 1 command per cycle sustained. Back-to-back reads give back-to-back rsp_valid pulses.
- Read after write to the same address in the queue returns the new data, because commands are issued strictly in order.

## Test plan
- Reset, then idle 5 cycles -> req_ready=1; all strobes, rsp_valid and busy 0; all data/address outputs 0.
- Write addr 3 data 8'hA5, then read addr 3 back-to-back -> mem_write pulses with addr 3/data A5. mem_read pulses the next cycle. rsp_valid pulses 3 cycles after the read's accept with rsp_addr=3, rsp_data=A5.
- Hold req_valid high for 6 reads at addrs 0–5 with memory preloaded to addr^8'h3C -> 6 consecutive rsp_valid pulses in order with data 3C,3D,3E,3F,38,39; req_ready never drops (drain rate equals fill rate).
- Stall draining is not possible, so fill with 4 pushes while rst was just released and check count: push 5 commands in 5 consecutive cycles -> all accepted, count ≤ 1, busy falls 3 cycles after the last read's strobe.
- Pointer wrap: 10 alternating writes/reads to addrs 31,0,31,0… -> pointers wrap twice; every read returns the preceding write's data; mem_read and mem_write are never high together.
- Assert rst one cycle after issuing a read to addr 7 -> no rsp_valid ever appears for it; all outputs return to reset values immediately (asynchronous); the next read after release works normally.

Source files
------------

// File: rtl/mem_req_queue.sv
// In-order request queue and sequencer in front of a synchronous memory.
// Commands enter over a valid/ready handshake and sit in a small FIFO.
// One command per cycle is issued as a single-cycle read or write strobe.
// Read data returns through a two-stage pipeline as a one-cycle rsp_valid pulse.
module mem_req_queue #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic              fifo_wr_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;

  // Stage A: the read strobe delayed by one cycle, aligned with mem_data_out.
  logic              a_valid_q;
  logic [ADDR_W-1:0] a_addr_q;

  logic              rsp_valid_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic push, pop;

  // Full is judged on the registered count, so a same-cycle pop does not free a slot.
  assign req_ready = (count_q != FullCount);
  assign push      = req_valid && req_ready;
  assign pop       = (count_q != '0);

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Issue stage: load the head entry; address and data hold when idle.
  always_comb begin
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if (pop) begin
      mem_write_d = fifo_wr_q[rd_ptr_q];
      mem_read_d  = !fifo_wr_q[rd_ptr_q];
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_data_d  = fifo_data_q[rd_ptr_q];
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_wr_q[i]   <= 1'b0;
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_wr_q[wr_ptr_q]   <= req_write;
        fifo_addr_q[wr_ptr_q] <= req_addr;
        fifo_data_q[wr_ptr_q] <= req_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue registers driving the memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  // Read return pipeline: stage A tracks the strobe, then data is captured into the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      a_valid_q   <= mem_read_q;
      a_addr_q    <= mem_addr_q;
      rsp_valid_q <= a_valid_q;
      if (a_valid_q) begin
        rsp_addr_q <= a_addr_q;
        rsp_data_q <= mem_data_out;
      end
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = pop || mem_read_q || mem_write_q || a_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue with a behavioural 32x8 synchronous memory.
module tb_mem_req_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       mem_read, mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out = '0;
  logic       rsp_valid;
  logic [4:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] mem [32];
  logic       overlap = 1'b0;
  logic [4:0] log_addr [$];
  logic [7:0] log_data [$];
  int         log_cyc  [$];

  mem_req_queue #(.ADDR_W(5), .DATA_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_addr     (rsp_addr),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: write on strobe, read data valid after the sampling edge.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addr];
  end

  // Response log and strobe exclusivity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      log_addr.push_back(rsp_addr);
      log_data.push_back(rsp_data);
      log_cyc.push_back(cyc);
    end
    if (mem_read && mem_write) overlap <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [4:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (log_addr.size() < target && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (log_addr.size() < target) begin
      n_err++;
      $display("FAIL rsp_timeout: got %0d responses, want %0d", log_addr.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (mem_addr !== 5'd0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (mem_data_in !== 8'h00) begin n_err++; $display("FAIL rst_mem_data: got %h want 0", mem_data_in); end
    n_vec++; if (rsp_addr !== 5'd0) begin n_err++; $display("FAIL rst_rsp_addr: got %h want 0", rsp_addr); end
    n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
  endtask

  task automatic test_write_read();
    int base = log_addr.size();
    set_cmd(1'b1, 5'd3, 8'hA5);
    tick();                                  // E0: write accepted
    set_cmd(1'b0, 5'd3, 8'h00);
    tick();                                  // E1: read accepted, write strobe up
    req_valid = 1'b0;
    n_vec++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_err++; $display("FAIL wr_strobe: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
    n_vec++; if (mem_addr !== 5'd3 || mem_data_in !== 8'hA5) begin n_err++; $display("FAIL wr_addr_data: got %h/%h want 03/a5", mem_addr, mem_data_in); end
    tick();                                  // E2: read strobe up
    n_vec++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 5'd3) begin n_err++; $display("FAIL rd_strobe: got r=%b w=%b a=%h want r=1 w=0 a=03", mem_read, mem_write, mem_addr); end
    tick();                                  // E3: stage A
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_early: got %b want 0", rsp_valid); end
    tick();                                  // E4: 3 edges after read accept
    n_vec++; if (rsp_valid !== 1'b1 || rsp_addr !== 5'd3 || rsp_data !== 8'hA5) begin n_err++; $display("FAIL rd_rsp: got v=%b a=%h d=%h want v=1 a=03 d=a5", rsp_valid, rsp_addr, rsp_data); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_pulse: got %b want 0", rsp_valid); end
    n_vec++; if (log_addr.size() != base + 1) begin n_err++; $display("FAIL rd_rsp_count: got %0d want %0d", log_addr.size() - base, 1); end
  endtask

  task automatic test_stream();
    int base;
    int ready_drops = 0;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, 5'(i), 8'(i) ^ 8'h3C);
      if (req_ready !== 1'b1) ready_drops++;
      tick();
    end
    base = log_addr.size();
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b0, 5'(i), 8'h00);
      if (req_ready !== 1'b1) ready_drops++;
      tick();
    end
    req_valid = 1'b0;
    n_vec++; if (ready_drops != 0) begin n_err++; $display("FAIL stream_ready: got %0d drops want 0", ready_drops); end
    wait_rsp(base + 6);
    for (int k = 0; k < 6; k++) begin
      exp = 8'(k) ^ 8'h3C;
      if (base + k < log_addr.size()) begin
        n_vec++;
        if (log_addr[base+k] !== 5'(k) || log_data[base+k] !== exp) begin
          n_err++;
          $display("FAIL stream_rsp%0d: got a=%h d=%h want a=%h d=%h", k, log_addr[base+k], log_data[base+k], 5'(k), exp);
        end
        if (k > 0) begin
          n_vec++;
          if (log_cyc[base+k] != log_cyc[base+k-1] + 1) begin
            n_err++;
            $display("FAIL stream_gap%0d: got cycle %0d want %0d", k, log_cyc[base+k], log_cyc[base+k-1] + 1);
          end
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int base = log_addr.size();
    logic       w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] a [5] = '{5'd10, 5'd11, 5'd11, 5'd10, 5'd11};
    logic [7:0] d [5] = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    logic [7:0] ed [3] = '{8'h22, 8'h11, 8'h22};
    logic [4:0] ea [3] = '{5'd11, 5'd10, 5'd11};
    int bad_ready = 0;
    int bad_count = 0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(w[i], a[i], d[i]);
      if (req_ready !== 1'b1) bad_ready++;
      tick();                                // P0..P4
      if (dut.count_q > 1) bad_count++;
    end
    req_valid = 1'b0;
    n_vec++; if (bad_ready != 0) begin n_err++; $display("FAIL b2b_accept: got %0d refusals want 0", bad_ready); end
    n_vec++; if (bad_count != 0) begin n_err++; $display("FAIL b2b_count: got %0d cycles over 1 want 0", bad_count); end
    tick();                                  // P5: last read strobe
    n_vec++; if (mem_read !== 1'b1 || mem_addr !== 5'd11) begin n_err++; $display("FAIL b2b_last_strobe: got r=%b a=%h want r=1 a=0b", mem_read, mem_addr); end
    tick();
    tick();                                  // P7
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_hold: got %b want 1", busy); end
    tick();                                  // P8
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_fall: got %b want 0", busy); end
    n_vec++; if (log_addr.size() != base + 3) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 3", log_addr.size() - base); end
    for (int k = 0; k < 3; k++) begin
      if (base + k < log_addr.size()) begin
        n_vec++;
        if (log_addr[base+k] !== ea[k] || log_data[base+k] !== ed[k]) begin
          n_err++;
          $display("FAIL b2b_rsp%0d: got a=%h d=%h want a=%h d=%h", k, log_addr[base+k], log_data[base+k], ea[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int base = log_addr.size();
    logic [4:0] a;
    logic [7:0] exp;
    for (int i = 0; i < 10; i++) begin
      a = ((i / 2) % 2 == 0) ? 5'd31 : 5'd0;
      set_cmd((i % 2) == 0, a, 8'h50 + 8'(i));
      tick();
    end
    req_valid = 1'b0;
    wait_rsp(base + 5);
    for (int k = 0; k < 5; k++) begin
      a   = (k % 2 == 0) ? 5'd31 : 5'd0;
      exp = 8'h50 + 8'(2 * k);
      if (base + k < log_addr.size()) begin
        n_vec++;
        if (log_addr[base+k] !== a || log_data[base+k] !== exp) begin
          n_err++;
          $display("FAIL wrap_rsp%0d: got a=%h d=%h want a=%h d=%h", k, log_addr[base+k], log_data[base+k], a, exp);
        end
      end
    end
    n_vec++; if (overlap !== 1'b0) begin n_err++; $display("FAIL strobe_exclusive: got %b want 0", overlap); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int base;
    set_cmd(1'b1, 5'd7, 8'hC7);
    tick();
    set_cmd(1'b0, 5'd7, 8'h00);
    tick();                                  // read accepted
    req_valid = 1'b0;
    tick();                                  // read strobe up
    base = log_addr.size();
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL mid_pre_strobe: got %b want 1", mem_read); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_flags: got r=%b w=%b busy=%b v=%b want all 0", mem_read, mem_write, busy, rsp_valid); end
    n_vec++; if (req_ready !== 1'b1 || mem_addr !== 5'd0 || mem_data_in !== 8'h00) begin n_err++; $display("FAIL mid_async_regs: got rdy=%b a=%h d=%h want 1/00/00", req_ready, mem_addr, mem_data_in); end
    repeat (2) tick();
    #2 rst = 1'b0;
    repeat (8) tick();
    n_vec++; if (log_addr.size() != base) begin n_err++; $display("FAIL mid_no_rsp: got %0d responses want 0", log_addr.size() - base); end
    set_cmd(1'b0, 5'd7, 8'h00);
    tick();
    req_valid = 1'b0;
    wait_rsp(base + 1);
    if (base < log_addr.size()) begin
      n_vec++;
      if (log_addr[base] !== 5'd7 || log_data[base] !== 8'hC7) begin
        n_err++;
        $display("FAIL mid_after_rsp: got a=%h d=%h want a=07 d=c7", log_addr[base], log_data[base]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stream();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
